// File: rtl/step_counter_if.sv
// step_counter_if: control/data bundle between a step_counter and whatever drives it.
// The master side drives the controls and the load/step values. The slave side (the counter) drives
// count, carry, borrow and zero.
// Optional feature macro: STEP_COUNTER_MAX_EN adds the max_val upper-bound input.
interface step_counter_if #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 2
);

  logic              clr;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic              en;
  logic              dir;
  logic [STEP_W-1:0] step;
  logic              sat;
`ifdef STEP_COUNTER_MAX_EN
  logic [WIDTH-1:0]  max_val;
`endif
  logic [WIDTH-1:0]  count;
  logic              carry;
  logic              borrow;
  logic              zero;

  modport master (
`ifdef STEP_COUNTER_MAX_EN
    output max_val,
`endif
    output clr, load, load_val, en, dir, step, sat,
    input  count, carry, borrow, zero
  );

  modport slave (
`ifdef STEP_COUNTER_MAX_EN
    input  max_val,
`endif
    input  clr, load, load_val, en, dir, step, sat,
    output count, carry, borrow, zero
  );

endinterface

// File: rtl/step_counter.sv
// step_counter: registered up/down counter with a programmable step.
// It can wrap or saturate at its bounds.
// carry and borrow are one-cycle pulses that allow counters to be cascaded. zero follows count combinationally.
// Optional feature macro: STEP_COUNTER_MAX_EN replaces the fixed all-ones upper bound with the max_val input.
// When that macro is undefined, the counter behaves exactly as if max_val were tied to all ones.
module step_counter #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 2
) (
  input logic           clk,
  input logic           reset,
  step_counter_if.slave bus
);

  // One extra bit so that sums and differences never lose their overflow information.
  localparam int EW = WIDTH + 1;

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             carry_q;
  logic             carry_d;
  logic             borrow_q;
  logic             borrow_d;

  logic [WIDTH-1:0] upper;
  logic [EW-1:0]    upperExt;
  logic [EW-1:0]    stepExt;
  logic [EW-1:0]    countExt;
  logic [EW-1:0]    sumExt;
  logic [EW-1:0]    downExt;
  logic [EW-1:0]    upWrapExt;
  logic [EW-1:0]    diffExt;
  logic [EW-1:0]    downWrapExt;
  logic [WIDTH-1:0] upWrap;
  logic [WIDTH-1:0] downWrap;
  logic             overUp;
  logic             underDown;
  logic             stepNonZero;

`ifdef STEP_COUNTER_MAX_EN
  assign upper = bus.max_val;
`else
  assign upper = '1;
`endif

  // Arithmetic datapath: the operands are widened by one bit.
  // The out-of-range tests and the wrap results are then exact for any count or upper bound.
  always_comb begin
    upperExt    = {1'b0, upper};
    stepExt     = EW'(bus.step);
    countExt    = {1'b0, count_q};
    stepNonZero = (bus.step != '0);

    sumExt      = countExt + stepExt;
    overUp      = (sumExt > upperExt);
    upWrapExt   = sumExt - upperExt - EW'(1);

    underDown   = (stepExt > countExt);
    downExt     = countExt - stepExt;
    diffExt     = stepExt - countExt;
    downWrapExt = upperExt + EW'(1) - diffExt;

    // A count that was loaded above the bound can produce a wrap result that is still out of range.
    // In that case the result is pinned to the bound.
    upWrap   = (upWrapExt > upperExt)   ? upper : upWrapExt[WIDTH-1:0];
    downWrap = (downWrapExt > upperExt) ? upper : downWrapExt[WIDTH-1:0];
  end

  // Next-state selection with priority clr > load > en > hold.
  // The flags default to zero so that they only pulse for a single cycle.
  always_comb begin
    count_d  = count_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (bus.clr) begin
      count_d = '0;
    end else if (bus.load) begin
      count_d = bus.load_val;
    end else if (bus.en && stepNonZero) begin
      if (bus.dir) begin
        if (overUp) begin
          carry_d = 1'b1;
          count_d = bus.sat ? upper : upWrap;
        end else begin
          count_d = sumExt[WIDTH-1:0];
        end
      end else begin
        if (underDown) begin
          borrow_d = 1'b1;
          count_d  = bus.sat ? '0 : downWrap;
        end else begin
          count_d = downExt[WIDTH-1:0];
        end
      end
    end
  end

  // State register: reset is active-low and asynchronous, and it overrides every synchronous control.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign bus.count  = count_q;
  assign bus.carry  = carry_q;
  assign bus.borrow = borrow_q;
  assign bus.zero   = (count_q == '0);

endmodule
